vfpu_add_ctrl: RTL
==================

Name: vfpu_add_ctrl

Overview:
Sequencing controller for the vfpu adder datapath. It accepts two IEEE-754 binary32 operands over independent valid/ready streams. It unpacks them into sign/exponent/mantissa with the hidden bit made explicit, pulses operands-ready into the adder, and waits for the adder's done. It then holds the pre-normalisation result on a valid/ready output toward the normaliser. It sits between the hwpe streamer-side operand sources and the adder, one operation in flight at a time.

Parameters:
- TIMEOUT_CYCLES, 64, cycles waiting for done_i before abort (used only with the optional feature).
- CNT_WIDTH, 16, width of completed-operation counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous abort/flush, highest priority after reset
- sub_i  in  1  1 = A-B (invert B sign), sampled at operand capture
- a_valid_i  in  1  operand A valid
- a_ready_o  out  1  operand A ready
- a_data_i  in  32  operand A, binary32
- b_valid_i  in  1  operand B valid
- b_ready_o  out  1  operand B ready
- b_data_i  in  32  operand B, binary32
- signA_o, signB_o  out  1  to adder
- exponentA_o, exponentB_o  out  FP_EXP_WIDTH  to adder
- mantissaA_o, mantissaB_o  out  FP_MANT_WIDTH+1  to adder, bit [FP_MANT_WIDTH] = hidden bit
- operandsReady_o  out  1  one-cycle start pulse to adder
- done_i  in  1  adder completion
- signPreNorm_i  in  1  adder result sign
- exponentPreNorm_i  in  FP_EXP_PRENORM_WIDTH  adder result exponent, signed
- mantissaPreNorm_i  in  FP_MANT_PRENORM_WIDTH  adder result mantissa
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result ready
- res_sign_o, res_exp_o, res_mant_o  out  as adder result  registered result
- busy_o  out  1  state != IDLE
- op_cnt_o  out  CNT_WIDTH  completed operations, wraps modulo 2^CNT_WIDTH
- err_o  out  1  sticky timeout flag (0 when feature disabled)

Behaviour:
- Reset: all outputs 0, state IDLE, operand/result registers 0, op_cnt_o 0, err_o 0.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - a_ready_o = b_ready_o = (a_valid_i & b_valid_i), so both operands are consumed in the same cycle and never one alone.
  - On handshake, register the unpacked operands: sign = bit31, exp = bits30:23, mant = {exp!=0, bits22:0}. signB = bit31 ^ sub_i.
  - Go to ISSUE.
- ISSUE: operandsReady_o = 1 for exactly this cycle; go to WAIT. Operand outputs stay stable from ISSUE until the next capture.
- WAIT:
  - On done_i, capture signPreNorm_i, exponentPreNorm_i and mantissaPreNorm_i into the res_* registers, then go to OUT.
  - done_i outside WAIT is ignored.
- OUT:
  - res_valid_o = 1; res_* stay stable while valid and not ready.
  - On res_ready_i, increment op_cnt_o and return to IDLE.
  - No new operand capture in the OUT cycle, so minimum issue interval = adder latency + 3 cycles.
- clear_i:
  - Any state goes to IDLE next cycle; res_valid_o is dropped and no operandsReady_o pulse is issued.
  - op_cnt_o and err_o are kept.
  - A done_i arriving in the same cycle as clear_i is discarded.
  - clear_i in IDLE while both operands are valid: ready is suppressed (no capture).
- Reset asserted mid-operation aborts immediately; the adder is not notified.
- Denormal (exp=0) gets hidden bit 0. Inf/NaN are passed through unmodified; they are handled downstream.

Optional Feature:
- Macro: VFPU_ADD_CTRL_TIMEOUT_EN.
- Enabled:
  - A counter runs in WAIT. If done_i is not seen within TIMEOUT_CYCLES cycles, the FSM goes to IDLE and err_o is set (sticky; cleared only by reset).
  - No result is emitted and op_cnt_o is unchanged.
- Disabled: no counter; WAIT waits indefinitely and err_o is tied 0.

Test Plan:
- Add 0x3F800000 + 0x40000000, sub_i=0 -> adder sees signA=0 expA=127 mantA=0x800000, signB=0 expB=128 mantB=0x800000; operandsReady_o high for exactly 1 cycle; adder-returned result appears on res_*; op_cnt_o goes 0->1.
- Same operands with sub_i=1 -> signB_o=1; the other fields are unchanged.
- a_valid_i=1 with b_valid_i=0 for 5 cycles -> a_ready_o stays 0 and there is no pulse. B arrives -> both are captured in the same cycle.
- Denormal 0x00000001 as A -> expA=0, mantA=0x000001 (hidden bit 0).
- res_ready_i held 0 for 10 cycles in OUT -> res_valid_o and res_* stay stable and a_ready_o stays 0. Release -> returns to IDLE and op_cnt_o increments once.
- clear_i in WAIT, then done_i -> no res_valid_o and op_cnt_o is unchanged. With VFPU_ADD_CTRL_TIMEOUT_EN and done_i never asserted -> after 64 cycles err_o=1 and state is IDLE.

Source files
------------

// File: rtl/vfpu_add_ctrl.sv
// vfpu_add_ctrl: sequencing controller in front of the vfpu adder datapath.
// It takes operands A and B from two valid/ready streams in the same cycle and
// unpacks them into sign, exponent and mantissa, with the hidden bit made explicit.
// It then pulses operandsReady_o, waits for done_i, and holds the pre-normalisation
// result on a valid/ready stream until the normaliser accepts it.
// Optional feature macro: VFPU_ADD_CTRL_TIMEOUT_EN. When it is defined, a WAIT
// timeout aborts the operation and sets the sticky err_o flag.
module vfpu_add_ctrl #(
    parameter int TIMEOUT_CYCLES        = 64,
    parameter int CNT_WIDTH             = 16,
    parameter int FP_EXP_WIDTH          = 8,
    parameter int FP_MANT_WIDTH         = 23,
    parameter int FP_EXP_PRENORM_WIDTH  = 10,
    parameter int FP_MANT_PRENORM_WIDTH = 28
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    input  logic                             sub_i,
    input  logic                             a_valid_i,
    output logic                             a_ready_o,
    input  logic [31:0]                      a_data_i,
    input  logic                             b_valid_i,
    output logic                             b_ready_o,
    input  logic [31:0]                      b_data_i,
    output logic                             signA_o,
    output logic                             signB_o,
    output logic [FP_EXP_WIDTH-1:0]          exponentA_o,
    output logic [FP_EXP_WIDTH-1:0]          exponentB_o,
    output logic [FP_MANT_WIDTH:0]           mantissaA_o,
    output logic [FP_MANT_WIDTH:0]           mantissaB_o,
    output logic                             operandsReady_o,
    input  logic                             done_i,
    input  logic                             signPreNorm_i,
    input  logic [FP_EXP_PRENORM_WIDTH-1:0]  exponentPreNorm_i,
    input  logic [FP_MANT_PRENORM_WIDTH-1:0] mantissaPreNorm_i,
    output logic                             res_valid_o,
    input  logic                             res_ready_i,
    output logic                             res_sign_o,
    output logic [FP_EXP_PRENORM_WIDTH-1:0]  res_exp_o,
    output logic [FP_MANT_PRENORM_WIDTH-1:0] res_mant_o,
    output logic                             busy_o,
    output logic [CNT_WIDTH-1:0]             op_cnt_o,
    output logic                             err_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    localparam int FIELD_W = FP_EXP_WIDTH + FP_MANT_WIDTH;

    // Hidden bit is 1 for any nonzero exponent (normals, Inf, NaN); denormals get 0.
    function automatic logic [FP_MANT_WIDTH:0] unpack_mant(input logic [FIELD_W-1:0] field);
        unpack_mant = {(|field[FP_MANT_WIDTH +: FP_EXP_WIDTH]), field[FP_MANT_WIDTH-1:0]};
    endfunction

    state_e                             state_r;
    logic                               sign_a_r, sign_b_r;
    logic [FP_EXP_WIDTH-1:0]            exp_a_r, exp_b_r;
    logic [FP_MANT_WIDTH:0]             mant_a_r, mant_b_r;
    logic                               res_sign_r;
    logic [FP_EXP_PRENORM_WIDTH-1:0]    res_exp_r;
    logic [FP_MANT_PRENORM_WIDTH-1:0]   res_mant_r;
    logic [CNT_WIDTH-1:0]               op_cnt_r;
    logic                               capture_s;

`ifdef VFPU_ADD_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]                   tmo_cnt_r;
    logic                               err_r;
    assign err_o = err_r;
`else
    logic                               unused_tmo_s;
    assign unused_tmo_s = (TIMEOUT_CYCLES == 32'sd0);
    assign err_o = 1'b0;
`endif

    // Both operands are taken together or not at all, and never while a flush is requested.
    assign capture_s       = (state_r == ST_IDLE) & a_valid_i & b_valid_i & ~clear_i;
    assign a_ready_o       = capture_s;
    assign b_ready_o       = capture_s;
    assign operandsReady_o = (state_r == ST_ISSUE) & ~clear_i;
    assign res_valid_o     = (state_r == ST_OUT) & ~clear_i;
    assign busy_o          = (state_r != ST_IDLE);
    assign signA_o         = sign_a_r;
    assign signB_o         = sign_b_r;
    assign exponentA_o     = exp_a_r;
    assign exponentB_o     = exp_b_r;
    assign mantissaA_o     = mant_a_r;
    assign mantissaB_o     = mant_b_r;
    assign res_sign_o      = res_sign_r;
    assign res_exp_o       = res_exp_r;
    assign res_mant_o      = res_mant_r;
    assign op_cnt_o        = op_cnt_r;

    // Controller FSM with operand, result, counter and timeout registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ST_IDLE;
            sign_a_r   <= 1'b0;
            sign_b_r   <= 1'b0;
            exp_a_r    <= '0;
            exp_b_r    <= '0;
            mant_a_r   <= '0;
            mant_b_r   <= '0;
            res_sign_r <= 1'b0;
            res_exp_r  <= '0;
            res_mant_r <= '0;
            op_cnt_r   <= '0;
`ifdef VFPU_ADD_CTRL_TIMEOUT_EN
            tmo_cnt_r  <= '0;
            err_r      <= 1'b0;
`endif
        end else if (clear_i) begin
            // Flush: abandon the operation, keep the counter and the sticky error.
            state_r    <= ST_IDLE;
`ifdef VFPU_ADD_CTRL_TIMEOUT_EN
            tmo_cnt_r  <= '0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (capture_s) begin
                        sign_a_r <= a_data_i[31];
                        exp_a_r  <= a_data_i[FP_MANT_WIDTH +: FP_EXP_WIDTH];
                        mant_a_r <= unpack_mant(a_data_i[FIELD_W-1:0]);
                        sign_b_r <= b_data_i[31] ^ sub_i;
                        exp_b_r  <= b_data_i[FP_MANT_WIDTH +: FP_EXP_WIDTH];
                        mant_b_r <= unpack_mant(b_data_i[FIELD_W-1:0]);
                        state_r  <= ST_ISSUE;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_WAIT;
`ifdef VFPU_ADD_CTRL_TIMEOUT_EN
                    tmo_cnt_r <= '0;
`endif
                end
                ST_WAIT: begin
                    if (done_i) begin
                        res_sign_r <= signPreNorm_i;
                        res_exp_r  <= exponentPreNorm_i;
                        res_mant_r <= mantissaPreNorm_i;
                        state_r    <= ST_OUT;
`ifdef VFPU_ADD_CTRL_TIMEOUT_EN
                    end else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        err_r      <= 1'b1;
                        tmo_cnt_r  <= '0;
                        state_r    <= ST_IDLE;
                    end else begin
                        tmo_cnt_r  <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
                        state_r    <= ST_WAIT;
`else
                    end else begin
                        state_r    <= ST_WAIT;
`endif
                    end
                end
                ST_OUT: begin
                    if (res_ready_i) begin
                        op_cnt_r <= op_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        state_r  <= ST_IDLE;
                    end else begin
                        state_r  <= ST_OUT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
